// File: rtl/regfile_wb_sink.sv
// Integer register file at the write-back end of the pipeline: selects and commits write-back
// data, serves two registered read ports with write-first bypass, and tracks pending writers.
module regfile_wb_sink #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   wb_alu_result_in,
    input  logic [XLEN-1:0]   wb_load_data_in,
    input  logic [XLEN-1:0]   wb_pc_plus4_in,
    input  logic [ADDR_W-1:0] wb_rd_addr_in,
    input  logic              wb_reg_write_en_in,
    input  logic [1:0]        wb_mem_to_reg_in,
    input  logic              rd_en_in,
    input  logic [ADDR_W-1:0] rs1_addr_in,
    input  logic [ADDR_W-1:0] rs2_addr_in,
    output logic [XLEN-1:0]   rs1_data_out,
    output logic [XLEN-1:0]   rs2_data_out,
    output logic              rd_valid_out,
    input  logic              issue_en_in,
    input  logic [ADDR_W-1:0] issue_rd_in,
    output logic              rs1_busy_out,
    output logic              rs2_busy_out,
    output logic              wb_err_out
);
    localparam int NREG = 2 ** ADDR_W;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;
    logic [XLEN-1:0] wdata;
    logic            wb_illegal;
    logic            wb_clear;
    logic            wb_commit;

    always_comb begin
        wdata = '0;
        case (wb_mem_to_reg_in)
            2'b00:   wdata = wb_alu_result_in;
            2'b01:   wdata = wb_load_data_in;
            2'b10:   wdata = wb_pc_plus4_in;
            default: wdata = '0;
        endcase
    end

    assign wb_illegal = wb_reg_write_en_in && (wb_mem_to_reg_in == 2'b11);
    // Clearing ignores the select so a bad write-back still releases its register.
    assign wb_clear   = wb_reg_write_en_in && (wb_rd_addr_in != '0);
    assign wb_commit  = wb_clear && (wb_mem_to_reg_in != 2'b11);

    // Set has priority over clear: the newly issued instruction owns the register.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                assign pending_next[gi] =
                    (issue_en_in && (issue_rd_in == ADDR_W'(gi))) ||
                    (pending_reg[gi] && !(wb_clear && (wb_rd_addr_in == ADDR_W'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            pending_reg  <= '0;
            rs1_data_out <= '0;
            rs2_data_out <= '0;
            rd_valid_out <= 1'b0;
            wb_err_out   <= 1'b0;
        end else begin
            if (wb_commit) begin
                regs[wb_rd_addr_in] <= wdata;
            end
            pending_reg  <= pending_next;
            rd_valid_out <= rd_en_in;
            if (wb_illegal) begin
                wb_err_out <= 1'b1;
            end
            if (rd_en_in) begin
                if (rs1_addr_in == '0)
                    rs1_data_out <= '0;
                else if (wb_commit && (wb_rd_addr_in == rs1_addr_in))
                    rs1_data_out <= wdata;
                else
                    rs1_data_out <= regs[rs1_addr_in];
                if (rs2_addr_in == '0)
                    rs2_data_out <= '0;
                else if (wb_commit && (wb_rd_addr_in == rs2_addr_in))
                    rs2_data_out <= wdata;
                else
                    rs2_data_out <= regs[rs2_addr_in];
            end
        end
    end

    // A write-back in flight this cycle un-stalls at once; the read bypass supplies its data.
    assign rs1_busy_out = (rs1_addr_in != '0) && pending_reg[rs1_addr_in] &&
                          !(wb_clear && (wb_rd_addr_in == rs1_addr_in));
    assign rs2_busy_out = (rs2_addr_in != '0) && pending_reg[rs2_addr_in] &&
                          !(wb_clear && (wb_rd_addr_in == rs2_addr_in));
endmodule

// File: tb/tb_regfile_wb_sink.sv
// Self-checking bench for regfile_wb_sink: directed scenarios followed by random traffic
// compared against an array-based reference of the register file and scoreboard.
module tb_regfile_wb_sink;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu, load, pc4;
    logic [4:0]  wb_rd;
    logic        wen;
    logic [1:0]  sel;
    logic        rd_en;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data;
    logic        rd_valid;
    logic        issue;
    logic [4:0]  issue_rd;
    logic        rs1_busy, rs2_busy;
    logic        wb_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    logic [31:0] m_rs1, m_rs2;
    logic        m_valid, m_err;

    always #5 clk = ~clk;

    regfile_wb_sink #(.XLEN(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .wb_alu_result_in(alu), .wb_load_data_in(load), .wb_pc_plus4_in(pc4),
        .wb_rd_addr_in(wb_rd), .wb_reg_write_en_in(wen), .wb_mem_to_reg_in(sel),
        .rd_en_in(rd_en), .rs1_addr_in(rs1), .rs2_addr_in(rs2),
        .rs1_data_out(rs1_data), .rs2_data_out(rs2_data), .rd_valid_out(rd_valid),
        .issue_en_in(issue), .issue_rd_in(issue_rd),
        .rs1_busy_out(rs1_busy), .rs2_busy_out(rs2_busy), .wb_err_out(wb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_rs1 = '0; m_rs2 = '0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic idle();
        alu = '0; load = '0; pc4 = '0; wb_rd = '0; wen = 1'b0; sel = 2'b00;
        rd_en = 1'b0; rs1 = '0; rs2 = '0; issue = 1'b0; issue_rd = '0;
    endtask

    function automatic logic [31:0] read_rule(input logic [4:0] a, input bit commit,
                                              input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (commit && wb_rd == a) return wd;
        return m_regs[a];
    endfunction

    // Inputs are driven just after a rising edge; this checks busy, advances the model and
    // checks the registered outputs one edge later.
    task automatic cycle(input string tag);
        logic [31:0] wd;
        bit commit, clr, b1, b2;
        #1;
        clr = wen && wb_rd != 0;
        commit = clr && sel != 2'b11;
        b1 = rs1 != 0 && m_pend[rs1] && !(clr && wb_rd == rs1);
        b2 = rs2 != 0 && m_pend[rs2] && !(clr && wb_rd == rs2);
        check({tag, "_busy1"}, {31'b0, rs1_busy}, {31'b0, b1});
        check({tag, "_busy2"}, {31'b0, rs2_busy}, {31'b0, b2});
        wd = (sel == 2'b00) ? alu : (sel == 2'b01) ? load : pc4;
        if (rd_en) begin
            m_rs1 = read_rule(rs1, commit, wd);
            m_rs2 = read_rule(rs2, commit, wd);
        end
        m_valid = rd_en;
        if (wen && sel == 2'b11) m_err = 1'b1;
        if (commit) m_regs[wb_rd] = wd;
        if (clr) m_pend[wb_rd] = 1'b0;
        if (issue && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_rs1"}, rs1_data, m_rs1);
        check({tag, "_rs2"}, rs2_data, m_rs2);
        check({tag, "_valid"}, {31'b0, rd_valid}, {31'b0, m_valid});
        check({tag, "_err"}, {31'b0, wb_err}, {31'b0, m_err});
    endtask

    task automatic wb(input logic [4:0] rd, input logic [1:0] s, input logic [31:0] v);
        wen = 1'b1; wb_rd = rd; sel = s; alu = v; load = v; pc4 = v;
        if (s == 2'b00) begin load = ~v; pc4 = v ^ 32'h1; end
        if (s == 2'b01) begin alu = ~v; pc4 = v ^ 32'h1; end
        if (s == 2'b10) begin alu = ~v; load = v ^ 32'h1; end
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        #12;
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_valid", {31'b0, rd_valid}, 32'h0);
        check("reset_err", {31'b0, wb_err}, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: all registers read zero; valid follows rd_en by one cycle
        for (int i = 0; i < 32; i++) begin
            idle(); rd_en = 1'b1; rs1 = 5'(i); rs2 = 5'(31 - i);
            cycle("t1_read");
            check("t1_zero", rs1_data | rs2_data, 32'h0);
            idle();
            cycle("t1_idle");
        end

        // 2: each write-back source
        idle(); wb(5, 2'b00, 32'hDEADBEEF); cycle("t2_alu");
        idle(); wb(6, 2'b01, 32'h12345678); cycle("t2_load");
        idle(); wb(1, 2'b10, 32'h00000104); cycle("t2_pc4");
        idle(); rd_en = 1'b1; rs1 = 5; rs2 = 6; cycle("t2_rd56");
        check("t2_x5", rs1_data, 32'hDEADBEEF);
        check("t2_x6", rs2_data, 32'h12345678);
        idle(); rd_en = 1'b1; rs1 = 1; rs2 = 0; cycle("t2_rd1");
        check("t2_x1", rs1_data, 32'h00000104);

        // 3: write-first bypass and x0
        idle(); wb(7, 2'b00, 32'hA5A5A5A5); rd_en = 1'b1; rs1 = 7; rs2 = 0; cycle("t3_byp");
        check("t3_x7", rs1_data, 32'hA5A5A5A5);
        check("t3_x0", rs2_data, 32'h0);
        idle(); wb(0, 2'b00, 32'h11111111); rd_en = 1'b1; rs1 = 0; rs2 = 0; cycle("t3_x0wr");
        check("t3_x0wr_zero", rs1_data, 32'h0);

        // 4: scoreboard set, same-cycle clear, set-beats-clear
        idle(); issue = 1'b1; issue_rd = 9; cycle("t4_issue");
        idle(); rs1 = 9; #1;
        check("t4_busy", {31'b0, rs1_busy}, 32'h1);
        wb(9, 2'b00, 32'h99); rd_en = 1'b1; #1;
        check("t4_unstall", {31'b0, rs1_busy}, 32'h0);
        cycle("t4_wb");
        check("t4_bypass", rs1_data, 32'h99);
        idle(); issue = 1'b1; issue_rd = 9; cycle("t4_reissue");
        idle(); issue = 1'b1; issue_rd = 9; wb(9, 2'b00, 32'h9A); cycle("t4_setwins");
        idle(); rs1 = 9; cycle("t4_after");
        check("t4_still_busy", {31'b0, rs1_busy}, 32'h1);
        idle(); wb(9, 2'b00, 32'h9B); cycle("t4_clear");

        // 5: illegal select
        idle(); issue = 1'b1; issue_rd = 3; cycle("t5_issue");
        idle(); wb(3, 2'b11, 32'h0000FFFF); cycle("t5_bad");
        check("t5_err", {31'b0, wb_err}, 32'h1);
        idle(); rd_en = 1'b1; rs1 = 3; cycle("t5_read");
        check("t5_x3", rs1_data, 32'h0);
        check("t5_nobusy", {31'b0, rs1_busy}, 32'h0);
        check("t5_sticky", {31'b0, wb_err}, 32'h1);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            alu = $urandom; load = $urandom; pc4 = $urandom;
            wen = ($urandom_range(0, 2) != 0);
            wb_rd = 5'($urandom_range(0, 31));
            sel = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rd_en = ($urandom_range(0, 3) != 0);
            rs1 = ($urandom_range(0, 1) != 0) ? wb_rd : 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            issue = ($urandom_range(0, 1) != 0);
            issue_rd = 5'($urandom_range(0, 31));
            cycle("rand");
        end

        // 6: asynchronous reset mid-cycle
        idle(); wb(4, 2'b00, 32'h55); cycle("t6_wr");
        idle(); rd_en = 1'b1; rs1 = 4; issue = 1'b1; issue_rd = 10; wb(0, 2'b11, 32'h0);
        cycle("t6_setup");
        check("t6_pre_x4", rs1_data, 32'h55);
        idle(); rs1 = 10; rs2 = 4;
        #2 rst = 1'b1;
        #1;
        check("t6_rs1", rs1_data, 32'h0);
        check("t6_rs2", rs2_data, 32'h0);
        check("t6_valid", {31'b0, rd_valid}, 32'h0);
        check("t6_err", {31'b0, wb_err}, 32'h0);
        check("t6_busy", {31'b0, rs1_busy}, 32'h0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        idle(); rd_en = 1'b1; rs1 = 4; rs2 = 10; cycle("t6_read");
        check("t6_x4", rs1_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
